dma_prog_sequencer: RTL and testbench
=====================================

Name: dma_prog_sequencer

Overview:
Multi-channel successor to the single-channel DMA register programming logic. It accepts MIPS DMA opcodes (56 word count, 57 source, 58 destination) tagged with a channel number. Each opcode expands into a fixed sequence of register writes to the 8237-style DMA controller, issued over a valid/ready bus. It sits between the MIPS execute stage and the DMA controller register port and tracks per-channel memory-source state.

Parameters:
DATA_W, 16, width of move_data and data_bus
ADDR_W, 16, width of Address_bus
NUM_CH, 4, number of DMA channels (1..16); CH_W = max(1, clog2(NUM_CH))
IO_LIMIT, 32764, highest memory address (8191*4); move_data > IO_LIMIT means peripheral

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
op_valid  in  1  opcode request valid
op_ready  out  1  sequencer can accept an opcode
op_code  in  6  opcode
op_ch  in  CH_W  target channel
move_data  in  DATA_W  address or count operand
bus_valid  out  1  register write valid
bus_ready  in  1  DMA controller accepts the write
Address_bus  out  ADDR_W  DMA register address
data_bus  out  DATA_W  DMA register data
busy  out  1  sequence in progress
err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Register map: BASE(ch)=2*ch, WC(ch)=2*ch+1. Globals use G=2*NUM_CH: CMD=G, REQ=G+1, MASK=G+2, MODE=G+3, DEST=G+4. Constants are zero-extended to DATA_W.
- Reset (async): state IDLE; bus_valid=0; Address_bus=0; data_bus=0; busy=0; err=0; pending_mem[NUM_CH-1:0]=0; step=0.
- op_ready is combinational and high iff state==IDLE, including during reset.
- An opcode is accepted on the cycle where op_valid&&op_ready. The operands are latched and the write list is chosen at acceptance. The state moves to EMIT and busy=1 from the next cycle.
- EMIT: bus_valid=1 with the write for the current step. Address_bus and data_bus are held stable until bus_ready is sampled high.
- On a handshake: step increments and the next write appears the following cycle. After the last handshake: state returns to IDLE, bus_valid=0, busy=0, step=0. Address_bus and data_bus hold their last values.
- The first write appears 1 cycle after acceptance. With bus_ready tied high, an N-write op occupies N cycles and op_ready returns on cycle N+1.
- Write lists (io = move_data > IO_LIMIT; equality counts as memory):
  - Op 56: WC(ch)=move_data. 1 write.
  - Op 57, io: CMD=0x80, MASK=ch, MODE=0x08|ch, REQ=0x04|ch. 4 writes. pending_mem[ch] cleared.
  - Op 57, !io: BASE(ch)=move_data, MASK=ch. 2 writes. pending_mem[ch] set at acceptance.
  - Op 58, pending_mem[ch] and !io (mem to mem): DEST=move_data, CMD=0x01, REQ=0x04|ch. 3 writes.
  - Op 58, pending_mem[ch] and io (mem to IO): MODE=0x04|ch, CMD=0x00, REQ=0x04|ch. 3 writes.
  - Op 58, !pending_mem[ch] and !io (IO to mem): BASE(ch)=move_data. 1 write.
  - Op 58, any case: pending_mem[ch] is cleared at acceptance.
- Illegal requests: op 58 with !pending_mem and io (IO to IO), or op_ch >= NUM_CH on any opcode 56-58.
  - The op is accepted, err pulses high for exactly 1 cycle (the cycle after acceptance), and there are no writes.
  - The state stays IDLE and pending_mem is unchanged.
- Other opcodes are accepted silently: no writes, no err, no state change.
- pending_mem is per channel; ops on one channel never alter another channel's flag.
- Asserting rst mid-sequence aborts immediately. Remaining writes are dropped, pending_mem clears, and bus_valid drops asynchronously.
- bus_ready while bus_valid=0 is ignored. op_valid while busy is not accepted and is not lost: the requester holds it.

Test Plan:
- Reset then op 56, ch2, data 0x0100, bus_ready=1 -> one write addr 5, data 0x0100, 1 cycle after acceptance; op_ready high again the next cycle.
- Op 57, ch1, data 0x9000 (io) -> writes {CMD 0x80, MASK 0x01, MODE 0x09, REQ 0x05} to addrs 8,10,11,9 on consecutive cycles.
- Op 57 ch0 data 0x7FFC, then op 58 ch0 data 0x1000 -> {BASE0=0x7FFC, MASK=0x00}, then {DEST(12)=0x1000, CMD=0x01, REQ=0x04}; pending_mem[0]=0 afterwards.
- Op 58 ch3 data 0x9000 with no prior source -> err pulse 1 cycle, no bus_valid. Op 57 ch3 data 0x0200 followed by op 58 ch1 -> ch1 takes the IO-to-mem path (BASE1 write) and pending_mem[3] stays 1.
- bus_ready low for 3 cycles on the second write of a 4-write op -> Address_bus and data_bus stable, op_ready low throughout, total 7 cycles.
- rst pulse during step 2 of a 3-write op -> bus_valid=0 at once, all outputs zero, pending_mem cleared, next op starts from step 0.

Source files
------------

// File: rtl/dma_prog_sequencer.sv
// rtl/dma_prog_sequencer.sv - expands tagged MIPS DMA opcodes into 8237-style register write sequences
module dma_prog_sequencer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NUM_CH   = 4,
  parameter int IO_LIMIT = 32764,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [5:0]        op_code,
  input  logic [CH_W-1:0]   op_ch,
  input  logic [DATA_W-1:0] move_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] Address_bus,
  output logic [DATA_W-1:0] data_bus,
  output logic              busy,
  output logic              err
);

  typedef enum logic {S_IDLE, S_EMIT} state_e;
  typedef enum logic [2:0] {P_WC, P_SRC_IO, P_SRC_MEM, P_M2M, P_M2IO, P_IO2M} path_e;

  localparam logic [ADDR_W-1:0] A_CMD  = ADDR_W'(2 * NUM_CH);
  localparam logic [ADDR_W-1:0] A_REQ  = ADDR_W'(2 * NUM_CH + 1);
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(2 * NUM_CH + 2);
  localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(2 * NUM_CH + 3);
  localparam logic [ADDR_W-1:0] A_DEST = ADDR_W'(2 * NUM_CH + 4);

  state_e              state_q, state_d;
  path_e               path_q, path_d;
  logic [1:0]          step_q, step_d;
  logic [2:0]          len_q, len_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   md_q, md_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                start;
  logic                io;
  logic                bad_ch;
  logic                legal_code;

  function automatic logic [ADDR_W-1:0] base_a(input logic [CH_W-1:0] ch);
    return ADDR_W'(ch) << 1;
  endfunction

  function automatic logic [DATA_W-1:0] req_d(input logic [CH_W-1:0] ch);
    return DATA_W'(8'h04) | DATA_W'(ch);
  endfunction

  // Write number idx of a sequence, packed as {address, data}.
  function automatic logic [ADDR_W+DATA_W-1:0] entry(input path_e p, input logic [CH_W-1:0] ch,
                                                     input logic [DATA_W-1:0] md, input logic [1:0] idx);
    logic [ADDR_W+DATA_W-1:0] e;
    e = '0;
    case (p)
      P_WC:      e = {base_a(ch) | ADDR_W'(1), md};
      P_SRC_IO:
        case (idx)
          2'd0:    e = {A_CMD, DATA_W'(8'h80)};
          2'd1:    e = {A_MASK, DATA_W'(ch)};
          2'd2:    e = {A_MODE, DATA_W'(8'h08) | DATA_W'(ch)};
          default: e = {A_REQ, req_d(ch)};
        endcase
      P_SRC_MEM: e = (idx == 2'd0) ? {base_a(ch), md} : {A_MASK, DATA_W'(ch)};
      P_M2M:
        case (idx)
          2'd0:    e = {A_DEST, md};
          2'd1:    e = {A_CMD, DATA_W'(8'h01)};
          default: e = {A_REQ, req_d(ch)};
        endcase
      P_M2IO:
        case (idx)
          2'd0:    e = {A_MODE, req_d(ch)};
          2'd1:    e = {A_CMD, DATA_W'(0)};
          default: e = {A_REQ, req_d(ch)};
        endcase
      default:   e = {base_a(ch), md};
    endcase
    return e;
  endfunction

  function automatic logic [2:0] path_len(input path_e p);
    case (p)
      P_SRC_IO:        return 3'd4;
      P_SRC_MEM:       return 3'd2;
      P_M2M, P_M2IO:   return 3'd3;
      default:         return 3'd1;
    endcase
  endfunction

  assign io         = 64'(move_data) > 64'(IO_LIMIT);
  assign bad_ch     = 32'(op_ch) >= 32'(NUM_CH);
  assign legal_code = (op_code == 6'd56) || (op_code == 6'd57) || (op_code == 6'd58);

  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    step_d  = step_q;
    len_d   = len_q;
    ch_d    = ch_q;
    md_d    = md_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && legal_code) begin
          if (bad_ch) begin
            err_d = 1'b1;
          end else begin
            start = 1'b1;
            case (op_code)
              6'd56: path_d = P_WC;
              6'd57: begin
                path_d        = io ? P_SRC_IO : P_SRC_MEM;
                pend_d[op_ch] = !io;
              end
              default: begin
                if (pend_q[op_ch]) path_d = io ? P_M2IO : P_M2M;
                else if (!io)      path_d = P_IO2M;
                else begin
                  start = 1'b0;
                  err_d = 1'b1;
                end
                if (start) pend_d[op_ch] = 1'b0;
              end
            endcase
          end
        end
        if (start) begin
          state_d           = S_EMIT;
          step_d            = 2'd0;
          ch_d              = op_ch;
          md_d              = move_data;
          len_d             = path_len(path_d);
          {addr_d, wdata_d} = entry(path_d, op_ch, move_data, 2'd0);
        end else begin
          path_d = path_q;
        end
      end
      default: begin
        if (bus_ready) begin
          if (3'(step_q) + 3'd1 == len_q) begin
            state_d = S_IDLE;
            step_d  = 2'd0;
          end else begin
            step_d            = step_q + 2'd1;
            {addr_d, wdata_d} = entry(path_q, ch_q, md_q, step_q + 2'd1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      path_q  <= P_WC;
      step_q  <= 2'd0;
      len_q   <= 3'd0;
      ch_q    <= '0;
      md_q    <= '0;
      pend_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      step_q  <= step_d;
      len_q   <= len_d;
      ch_q    <= ch_d;
      md_q    <= md_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign op_ready    = (state_q == S_IDLE);
  assign bus_valid   = (state_q == S_EMIT);
  assign busy        = (state_q == S_EMIT);
  assign Address_bus = addr_q;
  assign data_bus    = wdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dma_prog_sequencer.sv
// tb/tb_dma_prog_sequencer.sv - directed checks of the DMA programming sequencer
module tb_dma_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [5:0]  op_code;
  logic [1:0]  op_ch;
  logic [15:0] move_data;
  logic        bus_valid;
  logic        bus_ready;
  logic [15:0] Address_bus;
  logic [15:0] data_bus;
  logic        busy;
  logic        err;

  int passes = 0;
  int total  = 0;
  int busy_cycles;

  dma_prog_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_ch(op_ch), .move_data(move_data), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .Address_bus(Address_bus), .data_bus(data_bus), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [5:0] code, input logic [1:0] ch, input logic [15:0] md);
    chk("op_ready_before_issue", op_ready, 1);
    op_code = code; op_ch = ch; move_data = md; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  // Checks the write currently presented, then lets it handshake.
  task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d);
    chk({tag, "_valid"}, bus_valid, 1);
    chk({tag, "_addr"}, Address_bus, a);
    chk({tag, "_data"}, data_bus, d);
    tick();
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, bus_valid, 0);
    chk({tag, "_ready"}, op_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_ch = '0; move_data = '0; bus_ready = 1'b1;
    tick(); tick();
    chk("rst_op_ready", op_ready, 1);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_addr", Address_bus, 0);
    chk("rst_data", data_bus, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    issue(6'd56, 2'd2, 16'h0100);
    chk("wc_busy", busy, 1);
    chk("wc_op_ready", op_ready, 0);
    wr("wc", 16'd5, 16'h0100);
    idle_chk("wc_done");
    chk("wc_addr_hold", Address_bus, 5);

    issue(6'd57, 2'd1, 16'h9000);
    wr("srcio0", 16'd8, 16'h0080);
    wr("srcio1", 16'd10, 16'h0001);
    wr("srcio2", 16'd11, 16'h0009);
    wr("srcio3", 16'd9, 16'h0005);
    idle_chk("srcio_done");

    issue(6'd57, 2'd0, 16'h7FFC);
    wr("srcmem0", 16'd0, 16'h7FFC);
    wr("srcmem1", 16'd10, 16'h0000);
    issue(6'd58, 2'd0, 16'h1000);
    wr("m2m0", 16'd12, 16'h1000);
    wr("m2m1", 16'd8, 16'h0001);
    wr("m2m2", 16'd9, 16'h0004);
    idle_chk("m2m_done");
    issue(6'd58, 2'd0, 16'h1000);
    wr("pend0_cleared", 16'd0, 16'h1000);

    issue(6'd58, 2'd3, 16'h9000);
    chk("io2io_err", err, 1);
    chk("io2io_valid", bus_valid, 0);
    chk("io2io_ready", op_ready, 1);
    tick();
    chk("io2io_err_off", err, 0);
    chk("io2io_valid_after", bus_valid, 0);

    issue(6'd12, 2'd1, 16'h1234);
    chk("other_err", err, 0);
    chk("other_valid", bus_valid, 0);

    issue(6'd57, 2'd3, 16'h0200);
    wr("src3_0", 16'd6, 16'h0200);
    wr("src3_1", 16'd10, 16'h0003);
    issue(6'd58, 2'd1, 16'h0300);
    wr("io2m_ch1", 16'd2, 16'h0300);
    idle_chk("io2m_done");
    issue(6'd58, 2'd3, 16'h9000);
    wr("m2io0", 16'd11, 16'h0007);
    wr("m2io1", 16'd8, 16'h0000);
    wr("m2io2", 16'd9, 16'h0007);
    chk("m2io_err", err, 0);

    issue(6'd57, 2'd2, 16'hA000);
    busy_cycles = 0;
    if (busy) busy_cycles++;
    wr("stall0", 16'd8, 16'h0080);
    bus_ready = 1'b0;
    op_code = 6'd56; op_ch = 2'd0; move_data = 16'h0042; op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (busy) busy_cycles++;
      chk("stall_addr", Address_bus, 10);
      chk("stall_data", data_bus, 2);
      chk("stall_op_ready", op_ready, 0);
      tick();
    end
    bus_ready = 1'b1;
    if (busy) busy_cycles++;
    wr("stall1", 16'd10, 16'h0002);
    if (busy) busy_cycles++;
    wr("stall2", 16'd11, 16'h000A);
    if (busy) busy_cycles++;
    wr("stall3", 16'd9, 16'h0006);
    chk("stall_cycles", busy_cycles, 7);
    chk("held_op_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    wr("held_op", 16'd1, 16'h0042);
    idle_chk("held_done");

    issue(6'd57, 2'd0, 16'h0100);
    wr("pre_rst0", 16'd0, 16'h0100);
    wr("pre_rst1", 16'd10, 16'h0000);
    issue(6'd58, 2'd0, 16'h0200);
    wr("pre_rst2", 16'd12, 16'h0200);
    wr("pre_rst3", 16'd8, 16'h0001);
    chk("pre_rst_step2_addr", Address_bus, 9);
    rst = 1'b1;
    #1;
    chk("abort_valid", bus_valid, 0);
    chk("abort_addr", Address_bus, 0);
    chk("abort_data", data_bus, 0);
    chk("abort_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    issue(6'd58, 2'd0, 16'h0300);
    wr("post_rst", 16'd0, 16'h0300);
    idle_chk("post_rst_done");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
